cv_weights_fetcher: RTL and testbench

//  Parametrised weight-row fetch/unpack engine between the weights BRAM and the conv PE array.

---
 rtl/cv_weights_fetcher_if.sv | 29 ++
 rtl/cv_weights_fetcher.sv | 203 ++++++++++++++++++++
 tb/tb_cv_weights_fetcher.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv_weights_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module   : cv_weights_fetcher_if
// Brief    : Weights BRAM read port plus unpacked weight-vector stream.
// Revision : 1.0
// ============================================================================
interface cv_weights_fetcher_if #(
  parameter int ROW_W  = 512,
  parameter int ADDR_W = 11
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [ROW_W-1:0]  bram_dout;
  logic              vec_valid;
  logic              vec_ready;
  logic [ROW_W-1:0]  vec_data;
  logic              vec_last;

  modport master (
    output bram_en, bram_addr, vec_valid, vec_data, vec_last,
    input  bram_dout, vec_ready
  );

  modport slave (
    input  bram_en, bram_addr, vec_valid, vec_data, vec_last,
    output bram_dout, vec_ready
  );
endinterface
`default_nettype wire

// File: rtl/cv_weights_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : cv_weights_fetcher
// Brief    : Fetches packed weight rows from BRAM and emits one unpacked 8-bit
//            lane vector per beat (8/4/2-bit modes). Option: WT_OVERRUN_FLAG_EN.
// Revision : 1.0
// ============================================================================
module cv_weights_fetcher #(
  parameter int ROW_W  = 512,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_vec,
  input  logic                  abort,
  cv_weights_fetcher_if.master  bus,
  output logic                  busy,
  output logic                  done
`ifdef WT_OVERRUN_FLAG_EN
  , output logic                err_overrun
`endif
);

  localparam int c_LANES = ROW_W / 8;
  localparam int c_DEPTH = RD_LAT + 1;
  localparam int c_PW    = $clog2(c_DEPTH);
  localparam int c_CW    = $clog2(c_DEPTH + 1);
  localparam int c_HALF  = ROW_W / 2;
  localparam int c_QTR   = ROW_W / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sh;          // log2 of subrows per row
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rows_left;
  logic [CNT_W-1:0]  r_vec_left;
  logic [1:0]        r_sub;
  logic [ROW_W-1:0]  r_fifo [c_DEPTH];
  logic [c_PW-1:0]   r_wptr, r_rptr;
  logic [c_CW-1:0]   r_count, r_inflight;
  logic [RD_LAT-1:0] r_pend;

  logic [1:0]        w_sh_in, w_sub_max;
  logic [CNT_W-1:0]  w_rows_in;
  logic              w_start_ok, w_issue_start, w_issue_run, w_issue;
  logic              w_valid, w_last, w_accept, w_pop, w_arrive, w_room;
  logic [c_CW:0]     w_occ;
  logic [ROW_W-1:0]  w_head, w_unp;
  logic [c_HALF-1:0] w_half;
  logic [c_QTR-1:0]  w_qtr;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(c_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_sh_in   = 2'd0;
    w_rows_in = num_vec;
    case (mode)
      2'd1: begin
        w_sh_in   = 2'd2;
        w_rows_in = {2'b00, num_vec[CNT_W-1:2]} + CNT_W'(|num_vec[1:0]);
      end
      2'd2: begin
        w_sh_in   = 2'd1;
        w_rows_in = {1'b0, num_vec[CNT_W-1:1]} + CNT_W'(num_vec[0]);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_sh)
      2'd2:    w_sub_max = 2'd3;
      2'd1:    w_sub_max = 2'd1;
      default: w_sub_max = 2'd0;
    endcase
  end

  assign w_start_ok    = (r_state == S_IDLE) && start && !abort && !reset;
  assign w_issue_start = w_start_ok && (num_vec != '0);
  assign w_valid       = (r_state == S_RUN) && (r_count != '0);
  assign w_last        = (r_vec_left == CNT_W'(1));
  assign w_accept      = w_valid && bus.vec_ready;
  assign w_pop         = w_accept && ((r_sub == w_sub_max) || w_last);
  assign w_arrive      = r_pend[RD_LAT-1];

  // Rows already in the FIFO plus rows still in the BRAM pipe must fit; a pop this cycle frees one.
  assign w_occ       = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_room      = w_occ < ((c_CW+1)'(c_DEPTH) + {{c_CW{1'b0}}, w_pop});
  assign w_issue_run = (r_state == S_RUN) && !abort && !reset && (r_rows_left != '0) && w_room;
  assign w_issue     = w_issue_start || w_issue_run;

  assign bus.bram_en   = w_issue;
  assign bus.bram_addr = w_issue_start ? base_addr : r_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = (num_vec == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_addr      <= '0;
      r_rows_left <= '0;
      r_vec_left  <= '0;
      r_sub       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_inflight  <= '0;
      r_pend      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (abort) begin
        // Clearing the pending marks drops any read data still on its way back.
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_inflight <= '0;
        r_pend     <= '0;
        r_sub      <= '0;
      end else begin
        r_pend     <= RD_LAT'({r_pend, w_issue});
        r_inflight <= r_inflight + c_CW'(w_issue) - c_CW'(w_arrive);
        r_count    <= r_count + c_CW'(w_arrive) - c_CW'(w_pop);
        if (w_arrive) r_wptr <= f_inc(r_wptr);
        if (w_pop)    r_rptr <= f_inc(r_rptr);
        if (w_accept) begin
          r_vec_left <= r_vec_left - 1'b1;
          r_sub      <= ((r_sub == w_sub_max) || w_last) ? 2'd0 : r_sub + 1'b1;
        end
      end
      if (w_start_ok) begin
        r_sh        <= w_sh_in;
        r_vec_left  <= num_vec;
        r_rows_left <= w_rows_in - CNT_W'(w_issue_start);
        r_addr      <= base_addr + ADDR_W'(w_issue_start);
        r_sub       <= '0;
      end else if (w_issue_run) begin
        r_rows_left <= r_rows_left - 1'b1;
        r_addr      <= r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !abort && w_arrive) r_fifo[r_wptr] <= bus.bram_dout;
  end

  assign w_head = r_fifo[r_rptr];

  always_comb begin
    w_half = r_sub[0] ? w_head[ROW_W-1:c_HALF] : w_head[c_HALF-1:0];
    case (r_sub)
      2'd0:    w_qtr = w_head[c_QTR-1:0];
      2'd1:    w_qtr = w_head[2*c_QTR-1:c_QTR];
      2'd2:    w_qtr = w_head[3*c_QTR-1:2*c_QTR];
      default: w_qtr = w_head[ROW_W-1:3*c_QTR];
    endcase
    w_unp = '0;
    for (int i = 0; i < c_LANES; i++) begin
      case (r_sh)
        2'd2:    w_unp[8*i +: 8] = {6'b0, w_qtr[2*i +: 2]};
        2'd1:    w_unp[8*i +: 8] = {4'b0, w_half[4*i +: 4]};
        default: w_unp[8*i +: 8] = w_head[8*i +: 8];
      endcase
    end
  end

  assign bus.vec_valid = w_valid;
  assign bus.vec_data  = w_valid ? w_unp : '0;
  assign bus.vec_last  = w_valid && w_last;
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);

`ifdef WT_OVERRUN_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)                             err_overrun <= 1'b0;
    else if (start && (r_state == S_RUN))  err_overrun <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv_weights_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv_weights_fetcher
// Brief    : Directed bench for cv_weights_fetcher with a BRAM model (RD_LAT=3).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cv_weights_fetcher;
  localparam int ROW_W  = 512;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_vec;
  logic              busy, done;
`ifdef WT_OVERRUN_FLAG_EN
  logic              err_overrun;
`endif

  cv_weights_fetcher_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

  cv_weights_fetcher #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .base_addr(base_addr),
    .num_vec(num_vec),
    .abort(abort),
    .bus(bus.master),
    .busy(busy),
    .done(done)
`ifdef WT_OVERRUN_FLAG_EN
    , .err_overrun(err_overrun)
`endif
  );

  always #5 clk = ~clk;

  logic [ROW_W-1:0] mem  [0:(1<<ADDR_W)-1];
  logic [ROW_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.bram_en ? mem[bus.bram_addr] : {16{32'hDEADBEEF}};
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.bram_dout = pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, done_cyc, done_cnt, first_valid_cyc;
  logic [ADDR_W-1:0] addr_q[$];
  logic [ROW_W-1:0]  got_data[$];
  logic              got_last[$];
  int                got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.bram_en) addr_q.push_back(bus.bram_addr);
    if (bus.vec_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.vec_valid && bus.vec_ready) begin
      got_data.push_back(bus.vec_data);
      got_last.push_back(bus.vec_last);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    addr_q.delete();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    mode = m; base_addr = b; num_vec = n; start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; base_addr = '0; num_vec = '0;
    bus.vec_ready = 1'b0;
    clear_log();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.bram_en !== 1'b0) begin errors++; $display("FAIL reset_bram_en got %0b exp 0", bus.bram_en); end
    checks++; if (bus.bram_addr !== '0) begin errors++; $display("FAIL reset_bram_addr got %0h exp 0", bus.bram_addr); end
    checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL reset_vec_valid got %0b exp 0", bus.vec_valid); end
    checks++; if (bus.vec_data !== '0) begin errors++; $display("FAIL reset_vec_data got nonzero exp 0"); end
    checks++; if (bus.vec_last !== 1'b0) begin errors++; $display("FAIL reset_vec_last got %0b exp 0", bus.vec_last); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
`ifdef WT_OVERRUN_FLAG_EN
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL reset_err_overrun got %0b exp 0", err_overrun); end
`endif
    tick();
  endtask

  task automatic test_mode8();
    logic [7:0] b;
    for (int k = 0; k < 5; k++) begin b = 8'h40 + 8'(k); mem[11'h010 + k] = {64{b}}; end
    clear_log();
    bus.vec_ready = 1'b1;
    pulse_start(2'd0, 11'h010, 16'd5);
    wait_done();
    checks++; if (addr_q.size() != 5) begin errors++; $display("FAIL m8_nreads got %0d exp 5", addr_q.size()); end
    for (int k = 0; k < 5 && k < addr_q.size(); k++) begin
      checks++; if (addr_q[k] !== 11'(11'h010 + k)) begin errors++; $display("FAIL m8_addr%0d got %0h exp %0h", k, addr_q[k], 11'h010 + k); end
    end
    checks++; if (got_data.size() != 5) begin errors++; $display("FAIL m8_nvec got %0d exp 5", got_data.size()); end
    for (int k = 0; k < 5 && k < got_data.size(); k++) begin
      b = 8'h40 + 8'(k);
      checks++; if (got_data[k] !== {64{b}}) begin errors++; $display("FAIL m8_data%0d got %0h exp %0h", k, got_data[k][31:0], {4{b}}); end
      checks++; if (got_last[k] !== (k == 4)) begin errors++; $display("FAIL m8_last%0d got %0b exp %0b", k, got_last[k], k == 4); end
    end
    checks++; if (first_valid_cyc - start_cyc != RD_LAT + 1) begin errors++; $display("FAIL m8_latency got %0d exp %0d", first_valid_cyc - start_cyc, RD_LAT + 1); end
    if (got_cyc.size() == 5) begin
      checks++; if (got_cyc[4] - got_cyc[0] != 4) begin errors++; $display("FAIL m8_no_bubbles got span %0d exp 4", got_cyc[4] - got_cyc[0]); end
      checks++; if (done_cyc != got_cyc[4] + 1) begin errors++; $display("FAIL m8_done_cycle got %0d exp %0d", done_cyc, got_cyc[4] + 1); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL m8_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_mode2bit();
    logic [ROW_W-1:0] exp_v [6];
    mem[11'h100] = {128'h0, 128'h1B, {128{1'b1}}, 128'hE4};
    mem[11'h101] = {{128{1'b1}}, {128{1'b1}}, {64{2'b10}}, {64{2'b01}}};
    exp_v[0] = {480'h0, 32'h03020100};
    exp_v[1] = {64{8'h03}};
    exp_v[2] = {480'h0, 32'h00010203};
    exp_v[3] = '0;
    exp_v[4] = {64{8'h01}};
    exp_v[5] = {64{8'h02}};
    clear_log();
    bus.vec_ready = 1'b1;
    pulse_start(2'd1, 11'h100, 16'd6);
    wait_done();
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL m2_nreads got %0d exp 2", addr_q.size()); end
    if (addr_q.size() == 2) begin
      checks++; if ({addr_q[0], addr_q[1]} !== {11'h100, 11'h101}) begin errors++; $display("FAIL m2_addrs got %0h,%0h exp 100,101", addr_q[0], addr_q[1]); end
    end
    checks++; if (got_data.size() != 6) begin errors++; $display("FAIL m2_nvec got %0d exp 6", got_data.size()); end
    for (int k = 0; k < 6 && k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== exp_v[k]) begin errors++; $display("FAIL m2_data%0d got %0h exp %0h", k, got_data[k][63:0], exp_v[k][63:0]); end
      checks++; if (got_last[k] !== (k == 5)) begin errors++; $display("FAIL m2_last%0d got %0b exp %0b", k, got_last[k], k == 5); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL m2_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_mode4_stall();
    logic [ROW_W-1:0] exp_v [3];
    logic [15:0]      pat;
    logic             prev_stall, v, l;
    logic [ROW_W-1:0] prev_data, d;
    logic             prev_last;
    mem[11'h200] = {{32{8'h9C}}, {64{4'h7}}};
    mem[11'h201] = {{256{1'b1}}, {32{8'h5A}}};
    exp_v[0] = {64{8'h07}};
    exp_v[1] = {32{16'h090C}};
    exp_v[2] = {32{16'h050A}};
    pat = 16'b1010_0101_0010_0100;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    clear_log();
    bus.vec_ready = 1'b0;
    pulse_start(2'd2, 11'h200, 16'd3);
    for (int k = 0; k < 100 && done_cnt == 0; k++) begin
      bus.vec_ready = pat[k % 16];
      @(negedge clk);
      v = bus.vec_valid; d = bus.vec_data; l = bus.vec_last;
      if (prev_stall) begin
        checks++;
        if (v !== 1'b1 || d !== prev_data || l !== prev_last) begin
          errors++; $display("FAIL m4_stall_hold cyc %0d got v=%0b d=%0h exp v=1 d=%0h", cyc, v, d[31:0], prev_data[31:0]);
        end
      end
      prev_stall = v && !bus.vec_ready;
      prev_data = d; prev_last = l;
      tick();
    end
    bus.vec_ready = 1'b1;
    repeat (3) tick();
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL m4_nvec got %0d exp 3", got_data.size()); end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== exp_v[k]) begin errors++; $display("FAIL m4_data%0d got %0h exp %0h", k, got_data[k][31:0], exp_v[k][31:0]); end
      checks++; if (got_last[k] !== (k == 2)) begin errors++; $display("FAIL m4_last%0d got %0b exp %0b", k, got_last[k], k == 2); end
    end
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL m4_nreads got %0d exp 2", addr_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL m4_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [3];
    logic [7:0]        b;
    exp_a[0] = 11'h7FF; exp_a[1] = 11'h000; exp_a[2] = 11'h001;
    for (int k = 0; k < 3; k++) begin b = 8'hE1 + 8'(k); mem[exp_a[k]] = {64{b}}; end
    clear_log();
    bus.vec_ready = 1'b1;
    pulse_start(2'd0, 11'h7FF, 16'd3);
    wait_done();
    checks++; if (addr_q.size() != 3) begin errors++; $display("FAIL wrap_nreads got %0d exp 3", addr_q.size()); end
    for (int k = 0; k < 3 && k < addr_q.size(); k++) begin
      checks++; if (addr_q[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr%0d got %0h exp %0h", k, addr_q[k], exp_a[k]); end
    end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      b = 8'hE1 + 8'(k);
      checks++; if (got_data[k] !== {64{b}}) begin errors++; $display("FAIL wrap_data%0d got %0h exp %0h", k, got_data[k][31:0], {4{b}}); end
    end
  endtask

  task automatic test_zero_and_overrun();
    logic [7:0] b;
    clear_log();
    pulse_start(2'd0, 11'h050, 16'd0);
    repeat (3) tick();
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL zero_reads got %0d exp 0", addr_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt); end
    checks++; if (done_cyc != start_cyc + 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp %0d", done_cyc - start_cyc, 1); end

    for (int k = 0; k < 4; k++) begin b = 8'h60 + 8'(k); mem[11'h060 + k] = {64{b}}; end
    mem[11'h070] = {64{8'h77}};
    clear_log();
    bus.vec_ready = 1'b0;
    pulse_start(2'd0, 11'h060, 16'd4);
    repeat (2) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got %0b exp 1", busy); end
`ifdef WT_OVERRUN_FLAG_EN
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_flag_pre got %0b exp 0", err_overrun); end
`endif
    pulse_start(2'd1, 11'h070, 16'd1);
    tick();
`ifdef WT_OVERRUN_FLAG_EN
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag_post got %0b exp 1", err_overrun); end
`endif
    bus.vec_ready = 1'b1;
    wait_done();
    checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL ovr_nreads got %0d exp 4", addr_q.size()); end
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL ovr_nvec got %0d exp 4", got_data.size()); end
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      b = 8'h60 + 8'(k);
      checks++; if (got_data[k] !== {64{b}}) begin errors++; $display("FAIL ovr_data%0d got %0h exp %0h", k, got_data[k][31:0], {4{b}}); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ovr_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin b = 8'hB0 + 8'(k); mem[11'h300 + k] = {64{b}}; end
    for (int k = 0; k < 3; k++) begin b = 8'hC0 + 8'(k); mem[11'h320 + k] = {64{b}}; end
    clear_log();
    bus.vec_ready = 1'b1;
    pulse_start(2'd0, 11'h300, 16'd8);
    for (int k = 0; k < 50 && got_data.size() < 2; k++) tick();
    abort = 1'b1; bus.vec_ready = 1'b0;
    tick();
    abort = 1'b0;
    checks++; if (got_data.size() != 2) begin errors++; $display("FAIL abort_nvec got %0d exp 2", got_data.size()); end
    for (int k = 0; k < 2 && k < got_data.size(); k++) begin
      b = 8'hB0 + 8'(k);
      checks++; if (got_data[k] !== {64{b}}) begin errors++; $display("FAIL abort_data%0d got %0h exp %0h", k, got_data[k][31:0], {4{b}}); end
    end
    clear_log();
    bus.vec_ready = 1'b1;
    mode = 2'd0; base_addr = 11'h320; num_vec = 16'd3; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    checks++; if ({bus.vec_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_after got v/busy/done=%b exp 000", {bus.vec_valid, busy, done}); end
    tick();
    start = 1'b0;
    wait_done();
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL fresh_nvec got %0d exp 3", got_data.size()); end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      b = 8'hC0 + 8'(k);
      checks++; if (got_data[k] !== {64{b}}) begin errors++; $display("FAIL fresh_data%0d got %0h exp %0h", k, got_data[k][31:0], {4{b}}); end
      checks++; if (got_last[k] !== (k == 2)) begin errors++; $display("FAIL fresh_last%0d got %0b exp %0b", k, got_last[k], k == 2); end
    end
    checks++; if (addr_q.size() != 3) begin errors++; $display("FAIL fresh_nreads got %0d exp 3", addr_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fresh_done_count got %0d exp 1", done_cnt); end
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = {16{8'hA5, 5'h00, 11'(a), 8'h3C}};
    for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
    test_reset();
    test_mode8();
    test_mode2bit();
    test_mode4_stall();
    test_wrap();
    test_zero_and_overrun();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
